// File: rtl/mc.sv
// mc: memory-board measurement controller.
//
// Executes 32-bit instruction words taken either straight from an upstream FWFT FIFO
// (direct mode) or from an internal program RAM that is filled during a load phase and then
// replayed (memory mode). Drives external chip-selects and the timing-counter enable/clear.
//
// Build macro MC_LOOP_EN: when defined, a memory-mode program restarts from address 0 at its
// end and keeps looping while en is high; when undefined it parks in DONE until en drops.
//
// din_wr is a registered strobe: the FIFO head is latched in the cycle that decides to pop,
// and din_wr is raised in the following cycle. A new pop decision is never taken while a
// strobe is still in flight, so each latched word is popped exactly once.
// Assumes WAIT_W < 28.

module mc #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WAIT_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        prog_en,
    input  logic        direct,
    input  logic        din_empty,
    output logic        din_wr,
    input  logic [31:0] din,
    output logic [2:0]  ext_cs,
    output logic        clk_en,
    output logic        clk_clr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StDfetch = 3'd2;
    localparam logic [2:0] StMfetch = 3'd3;
    localparam logic [2:0] StExec   = 3'd4;
    localparam logic [2:0] StWait   = 3'd5;
    localparam logic [2:0] StDone   = 3'd6;

    localparam logic [3:0] OpCs   = 4'h1;
    localparam logic [3:0] OpWait = 4'h2;
    localparam logic [3:0] OpClr  = 4'h3;
    localparam logic [3:0] OpTen  = 4'h4;
    localparam logic [3:0] OpEnd  = 4'hF;

    // Pointers carry one extra bit so a completely full RAM (DEPTH words) is representable.
    localparam logic [ADDR_W:0]   PtrFull = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   PtrOne  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] CntOne  = {{(WAIT_W-1){1'b0}}, 1'b1};

`ifdef MC_LOOP_EN
    localparam bit LoopEn = 1'b1;
`else
    localparam bit LoopEn = 1'b0;
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]       instr_q, instr_d;
    logic              mode_direct_q, mode_direct_d;
    logic [2:0]        ext_cs_q, ext_cs_d;
    logic              clk_en_q, clk_en_d;
    logic              clk_clr_q, clk_clr_d;
    logic              din_wr_q, din_wr_d;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;
    logic              ram_we;
    logic [ADDR_W-1:0] rd_addr;

    logic [31:0]       exec_word;
    logic [3:0]        op;
    logic [WAIT_W-1:0] wait_arg;
    logic [ADDR_W:0]   rd_ptr_inc;
    logic              in_run;
    logic              run_abort;
    logic              unused_arg;

    assign exec_word  = mode_direct_q ? instr_q : ram_q;
    assign op         = exec_word[31:28];
    assign wait_arg   = exec_word[WAIT_W-1:0];
    assign unused_arg = ^exec_word[27:WAIT_W];
    assign rd_ptr_inc = rd_ptr_q + PtrOne;

    // While executing from RAM, prefetch the next word so consecutive instructions run
    // back to back; otherwise read the word at the current pointer.
    assign rd_addr = (state_q == StExec) ? rd_ptr_inc[ADDR_W-1:0] : rd_ptr_q[ADDR_W-1:0];

    assign in_run = (state_q == StDfetch) || (state_q == StMfetch) || (state_q == StExec) ||
                    (state_q == StWait) || (state_q == StDone);
    assign run_abort = !en || prog_en;

    assign din_wr  = din_wr_q;
    assign ext_cs  = ext_cs_q;
    assign clk_en  = clk_en_q;
    assign clk_clr = clk_clr_q;

    // Program RAM: written during the load phase, registered read for replay.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= din;
        end
        ram_q <= mem[rd_addr];
    end

    // Next-state, pointer and output decisions.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        prog_len_d    = prog_len_q;
        wait_cnt_d    = wait_cnt_q;
        instr_d       = instr_q;
        mode_direct_d = mode_direct_q;
        ext_cs_d      = ext_cs_q;
        clk_en_d      = clk_en_q;
        clk_clr_d     = 1'b0;
        din_wr_d      = 1'b0;
        ram_we        = 1'b0;

        if (in_run && run_abort) begin
            // Abort: park in IDLE with outputs quiet; IDLE then honours prog_en if raised.
            state_d    = StIdle;
            ext_cs_d   = 3'b000;
            clk_en_d   = 1'b0;
            wait_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (prog_en) begin
                        state_d  = StLoad;
                        wr_ptr_d = '0;
                    end else if (en) begin
                        mode_direct_d = direct;
                        if (direct) begin
                            state_d = StDfetch;
                        end else begin
                            state_d  = StMfetch;
                            rd_ptr_d = '0;
                        end
                    end
                end

                StLoad: begin
                    if (!prog_en) begin
                        prog_len_d = wr_ptr_q;
                        state_d    = StIdle;
                    end else if (!din_empty && !din_wr_q && (wr_ptr_q != PtrFull)) begin
                        ram_we   = 1'b1;
                        din_wr_d = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrOne;
                    end
                end

                StDfetch: begin
                    if (!din_empty && !din_wr_q) begin
                        instr_d  = din;
                        din_wr_d = 1'b1;
                        state_d  = StExec;
                    end
                end

                StMfetch: begin
                    if (rd_ptr_q == prog_len_q) begin
                        if (LoopEn && (prog_len_q != '0)) begin
                            rd_ptr_d = '0;
                            state_d  = StMfetch;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        state_d = StExec;
                    end
                end

                StExec: begin
                    case (op)
                        OpCs:    ext_cs_d  = exec_word[2:0];
                        OpClr:   clk_clr_d = 1'b1;
                        OpTen:   clk_en_d  = exec_word[0];
                        default: ;
                    endcase

                    if (mode_direct_q) begin
                        // END is just another word in direct mode.
                        if ((op == OpWait) && (wait_arg != '0)) begin
                            wait_cnt_d = wait_arg;
                            state_d    = StWait;
                        end else begin
                            state_d = StDfetch;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_inc;
                        if ((op == OpEnd) || ((op != OpWait) && (rd_ptr_inc == prog_len_q))) begin
                            if (LoopEn) begin
                                rd_ptr_d = '0;
                                state_d  = StMfetch;
                            end else begin
                                state_d = StDone;
                            end
                        end else if ((op == OpWait) && (wait_arg != '0)) begin
                            wait_cnt_d = wait_arg;
                            state_d    = StWait;
                        end else if (rd_ptr_inc == prog_len_q) begin
                            // Zero-length WAIT as the last word: let MFETCH see the end.
                            state_d = StMfetch;
                        end else begin
                            state_d = StExec;
                        end
                    end
                end

                StWait: begin
                    if (wait_cnt_q == CntOne) begin
                        wait_cnt_d = '0;
                        state_d    = mode_direct_q ? StDfetch : StMfetch;
                    end else begin
                        wait_cnt_d = wait_cnt_q - CntOne;
                    end
                end

                StDone: ;

                default: state_d = StIdle;
            endcase
        end
    end

    // Control state and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            prog_len_q    <= '0;
            wait_cnt_q    <= '0;
            instr_q       <= '0;
            mode_direct_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            prog_len_q    <= prog_len_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_q       <= instr_d;
            mode_direct_q <= mode_direct_d;
        end
    end

    // Registered outputs and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_cs_q  <= 3'b000;
            clk_en_q  <= 1'b0;
            clk_clr_q <= 1'b0;
            din_wr_q  <= 1'b0;
        end else begin
            ext_cs_q  <= ext_cs_d;
            clk_en_q  <= clk_en_d;
            clk_clr_q <= clk_clr_d;
            din_wr_q  <= din_wr_d;
        end
    end

endmodule

// File: tb/tb_mc.sv
// tb_mc: directed plus randomized bench for mc with an FWFT FIFO model and a timing-level
// reference model of instruction execution. Works with or without MC_LOOP_EN.

module tb_mc;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WAIT_W = 24;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam int          MAXOBS = 128;

`ifdef MC_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        prog_en;
    logic        direct;
    logic        din_empty;
    logic        din_wr;
    logic [31:0] din;
    logic [2:0]  ext_cs;
    logic        clk_en;
    logic        clk_clr;

    always #5 clk = ~clk;

    mc #(
        .ADDR_W(ADDR_W),
        .WAIT_W(WAIT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .prog_en  (prog_en),
        .direct   (direct),
        .din_empty(din_empty),
        .din_wr   (din_wr),
        .din      (din),
        .ext_cs   (ext_cs),
        .clk_en   (clk_en),
        .clk_clr  (clk_clr)
    );

    logic [31:0] fifo[$];
    logic [5:0]  tr[$];             // observed {din_wr, clk_clr, clk_en, ext_cs} per cycle
    logic [5:0]  exp_tr[MAXOBS];
    logic [31:0] p[$];
    int          checks   = 0;
    int          failures = 0;
    int          pulses   = 0;
    int          viol     = 0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        din_empty = (fifo.size() == 0);
        din       = din_empty ? 32'h0 : fifo[0];
    endtask

    // One clock: observe at the falling edge, then apply the FIFO pop after the rising edge.
    task automatic cycle();
        logic pw;
        @(negedge clk);
        pw = din_wr;
        tr.push_back({din_wr, clk_clr, clk_en, ext_cs});
        if (din_wr) pulses++;
        if (din_wr && din_empty) viol++;
        @(posedge clk);
        #1;
        if (pw && (fifo.size() > 0)) fifo.delete(0);
        refresh();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Expected trace from the instruction list. Observation 0 is the cycle in which en is
    // first presented; the first instruction executes in observation 2 and its effect shows
    // from observation 3. Direct: 2 cycles per word plus WAIT stalls, pop seen in the
    // execute cycle. Memory: 1 cycle per word, a nonzero WAIT costs its count plus a refetch,
    // end of program costs a refetch before looping (or stops without loop).
    task automatic model(input logic [31:0] prog[$], input bit dmode, input int n);
        int          t;
        int          i;
        int          w;
        logic [31:0] word;
        logic [3:0]  op;
        logic [2:0]  cs;
        logic        ten;
        for (int k = 0; k < MAXOBS; k++) exp_tr[k] = 6'd0;
        cs  = 3'd0;
        ten = 1'b0;
        t   = 2;
        i   = 0;
        while ((t < n) && (i < prog.size())) begin
            word = prog[i];
            op   = word[31:28];
            if (dmode) exp_tr[t][5] = 1'b1;
            if (op == 4'h1) cs = word[2:0];
            if (op == 4'h4) ten = word[0];
            for (int k = t + 1; k < n; k++) exp_tr[k][3:0] = {ten, cs};
            if ((op == 4'h3) && (t + 1 < n)) exp_tr[t+1][4] = 1'b1;
            w = (op == 4'h2) ? int'(word[WAIT_W-1:0]) : 0;
            i++;
            if (dmode) begin
                t += 2 + w;
            end else if ((op == 4'hF) || (i == prog.size())) begin
                if (!LOOP) break;
                i = 0;
                t += 2;
            end else begin
                t += (w > 0) ? (w + 2) : 1;
            end
        end
    endtask

    task automatic compare(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s[%0d]", tag, k), 32'(tr[k]), 32'(exp_tr[k]));
        end
    endtask

    task automatic load(input logic [31:0] prog[$], input string tag);
        int guard;
        fifo = prog;
        refresh();
        prog_en = 1'b1;
        pulses  = 0;
        guard   = 0;
        run(2);
        while (((fifo.size() != 0) || din_wr) && (guard < 4 * DEPTH)) begin
            cycle();
            guard++;
        end
        prog_en = 1'b0;
        run(2);
        check({tag, "_load_pops"}, 32'(pulses), 32'(prog.size()));
    endtask

    task automatic run_check(input logic [31:0] prog[$], input bit dmode, input int n,
                             input string tag);
        if (dmode) begin
            fifo = prog;
            refresh();
        end
        direct = dmode;
        en     = 1'b1;
        tr     = {};
        pulses = 0;
        run(n);
        model(prog, dmode, n);
        compare(tag, n);
        en = 1'b0;
        run(2);
    endtask

    function automatic logic [31:0] rand_instr(input bit allow_end);
        int sel;
        sel = int'($urandom_range(0, 6));
        if (!allow_end && (sel == 5)) sel = 0;
        case (sel)
            0:       return {4'h0, 28'($urandom)};
            1:       return {4'h1, 28'($urandom)};
            2:       return {4'h2, 28'($urandom_range(0, 5))};
            3:       return {4'h3, 28'h0};
            4:       return {4'h4, 28'($urandom)};
            5:       return {4'hF, 28'h0};
            default: return {4'h7, 28'($urandom)};
        endcase
    endfunction

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        prog_en = 1'b0;
        direct  = 1'b0;
        fifo    = {};
        refresh();

        // Reset: all outputs low.
        run(3);
        check("reset_out1", 32'(tr[1]), 32'h0);
        check("reset_out2", 32'(tr[2]), 32'h0);
        rst = 1'b0;

        // Direct run on an empty FIFO never pops.
        direct = 1'b1;
        en     = 1'b1;
        pulses = 0;
        run(5);
        check("empty_no_pop", 32'(pulses), 32'h0);
        en = 1'b0;
        run(2);

        // Single CS word.
        p = {};
        p.push_back(32'h1000_0005);
        run_check(p, 1'b1, 6, "dir_cs");
        check("dir_cs_pops", 32'(pulses), 32'd1);

        // TEN, WAIT 4, CLR.
        p = {};
        p.push_back(32'h4000_0001);
        p.push_back(32'h2000_0004);
        p.push_back(32'h3000_0000);
        run_check(p, 1'b1, 16, "dir_wait");
        check("dir_wait_clr_at_11", 32'(tr[11][4]), 32'd1);

        // Drop en in the middle of a long WAIT.
        p = {};
        p.push_back(32'h1000_0006);
        p.push_back(32'h4000_0001);
        p.push_back(32'h2000_03E8);
        p.push_back(32'h1000_0001);
        fifo = p;
        refresh();
        direct = 1'b1;
        en     = 1'b1;
        tr     = {};
        pulses = 0;
        run(11);
        en = 1'b0;
        run(5);
        model(p, 1'b1, 12);
        compare("abort_pre", 12);
        for (int k = 12; k < 16; k++) begin
            check($sformatf("abort_idle[%0d]", k), 32'(tr[k]), 32'h0);
        end
        check("abort_pops", 32'(pulses), 32'd3);
        check("abort_fifo_left", 32'(fifo.size()), 32'd1);
        fifo = {};
        refresh();

        // Overfill the program RAM: only DEPTH words are taken.
        fifo = {};
        for (int k = 0; k <= DEPTH; k++) fifo.push_back(32'(k));
        refresh();
        prog_en = 1'b1;
        pulses  = 0;
        run(4 * DEPTH + 20);
        check("full_pops", 32'(pulses), 32'(DEPTH));
        check("full_fifo_left", 32'(fifo.size()), 32'd1);
        prog_en = 1'b0;
        run(2);
        fifo = {};
        refresh();

        // Memory-mode program from the reference scenario.
        p = {};
        p.push_back(32'h1000_0002);
        p.push_back(32'h4000_0001);
        p.push_back(32'hF000_0000);
        load(p, "mem3");
        run_check(p, 1'b0, 20, "mem3");

        // CLR first makes the loop period visible on clk_clr.
        p = {};
        p.push_back(32'h3000_0000);
        p.push_back(32'h1000_0003);
        p.push_back(32'hF000_0000);
        load(p, "memclr");
        run_check(p, 1'b0, 20, "memclr");
        check("memclr_second_clr", 32'(tr[7][4]), 32'(LOOP));

        // prog_en raised during a memory run aborts, then loads.
        p = {};
        p.push_back(32'h1000_0004);
        p.push_back(32'h4000_0001);
        load(p, "mem2");
        direct = 1'b0;
        en     = 1'b1;
        tr     = {};
        run(8);
        model(p, 1'b0, 8);
        compare("mem2", 8);
        fifo = {};
        fifo.push_back(32'h4000_0001);
        refresh();
        prog_en = 1'b1;
        tr      = {};
        pulses  = 0;
        run(8);
        check("pe_abort_out", 32'(tr[1]), 32'h0);
        check("pe_load_pops", 32'(pulses), 32'd1);
        prog_en = 1'b0;
        en      = 1'b0;
        run(2);
        p = {};
        p.push_back(32'h4000_0001);
        run_check(p, 1'b0, 10, "mem1");

        // Empty program: DONE at once, no pops from the FIFO.
        p = {};
        load(p, "mem0");
        fifo = {};
        fifo.push_back(32'h1000_0007);
        refresh();
        run_check(p, 1'b0, 8, "mem0");
        check("mem0_no_pop", 32'(pulses), 32'h0);
        fifo = {};
        refresh();

        // Randomized programs in both modes.
        for (int r = 0; r < 4; r++) begin
            p = {};
            for (int k = 0; k < 6; k++) p.push_back(rand_instr(1'b1));
            run_check(p, 1'b1, 48, $sformatf("rnd_dir%0d", r));
            p = {};
            for (int k = 0; k < 5; k++) p.push_back(rand_instr(1'b1));
            p.push_back(32'hF000_0000);
            load(p, $sformatf("rnd_mem%0d", r));
            run_check(p, 1'b0, 40, $sformatf("rnd_mem%0d", r));
        end

        check("wr_while_empty", 32'(viol), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
